// File: rtl/verlet_position_updater_if.sv
// ---------------------------------------------------------------------------
// verlet_position_updater_if
//
// Bundles every non-clock, non-reset signal of the Verlet position updater.
// The updater sits on the slave side: it receives the start strobe and the
// selected node's data, and it produces the node selector and the
// write-back beat for the node position RAM. The surrounding datapath
// (selector mux, force stage, position RAM) sits on the master side.
//
// Signals (all words are WIDTH bits, signed two's complement):
//   start           master -> slave  begin one pass over all nodes
//   x_position      master -> slave  current x of the selected node
//   y_position      master -> slave  current y of the selected node
//   pre_x_position  master -> slave  previous x of the selected node
//   pre_y_position  master -> slave  previous y of the selected node
//   disp_x          master -> slave  accel*dt^2 in x for the selected node
//   disp_y          master -> slave  accel*dt^2 in y for the selected node
//   selector        slave -> master  one-hot node select
//   wr_en           slave -> master  write-back strobe, one cycle per node
//   wr_index        slave -> master  index of the node being written
//   new_x           slave -> master  updated x
//   new_y           slave -> master  updated y
//   new_pre_x       slave -> master  new previous x (old x)
//   new_pre_y       slave -> master  new previous y (old y)
//   busy            slave -> master  pass in progress
//   done            slave -> master  one-cycle end-of-pass pulse
//   overflow        slave -> master  sticky saturation flag for the pass
// ---------------------------------------------------------------------------
interface verlet_position_updater_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic [WIDTH-1:0] x_position;
    logic [WIDTH-1:0] y_position;
    logic [WIDTH-1:0] pre_x_position;
    logic [WIDTH-1:0] pre_y_position;
    logic [WIDTH-1:0] disp_x;
    logic [WIDTH-1:0] disp_y;
    logic [WIDTH-1:0] selector;
    logic             wr_en;
    logic [WIDTH-1:0] wr_index;
    logic [WIDTH-1:0] new_x;
    logic [WIDTH-1:0] new_y;
    logic [WIDTH-1:0] new_pre_x;
    logic [WIDTH-1:0] new_pre_y;
    logic             busy;
    logic             done;
    logic             overflow;

    // Datapath side: drives node data, consumes the write-back beat.
    modport master (
        output start,
        output x_position,
        output y_position,
        output pre_x_position,
        output pre_y_position,
        output disp_x,
        output disp_y,
        input  selector,
        input  wr_en,
        input  wr_index,
        input  new_x,
        input  new_y,
        input  new_pre_x,
        input  new_pre_y,
        input  busy,
        input  done,
        input  overflow
    );

    // Updater side.
    modport slave (
        input  start,
        input  x_position,
        input  y_position,
        input  pre_x_position,
        input  pre_y_position,
        input  disp_x,
        input  disp_y,
        output selector,
        output wr_en,
        output wr_index,
        output new_x,
        output new_y,
        output new_pre_x,
        output new_pre_y,
        output busy,
        output done,
        output overflow
    );

endinterface

// File: rtl/verlet_position_updater.sv
// ---------------------------------------------------------------------------
// verlet_position_updater
//
// One simulation step of the graph-layout datapath: walks nodes
// 0..NODE_COUNT-1, and for each node selects it, captures its current and
// previous position plus the force-stage displacement, computes
//    new = 2*cur - prev + disp   (saturated to WIDTH bits)
// and emits a single write-back beat to the node position RAM.
//
// Each node costs three cycles (SELECT, CALC, WRITE); a DONE cycle closes
// the pass. With start sampled at edge 0, node k is written in cycle 3k+3
// and done pulses in cycle 3*NODE_COUNT+1.
//
// Parameters:
//   WIDTH       word width of positions, displacements and selector
//   NODE_COUNT  nodes per pass, 1 <= NODE_COUNT <= WIDTH (selector is
//               one-hot over WIDTH bits)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset; aborts a pass in progress
//   bus   slave side of verlet_position_updater_if (start, node data in,
//         selector and write-back beat out, busy/done/overflow status)
// ---------------------------------------------------------------------------
module verlet_position_updater #(
    parameter int WIDTH      = 32,
    parameter int NODE_COUNT = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    verlet_position_updater_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CALC,
        WRITE,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NODE_COUNT - 1);

    // Saturation bounds expressed in the widened arithmetic domain.
    localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;
    logic [WIDTH-1:0] selector_q;
    logic [WIDTH-1:0] selector_d;

    // Node operands captured at the end of SELECT.
    logic [WIDTH-1:0] curX_q;
    logic [WIDTH-1:0] curY_q;
    logic [WIDTH-1:0] preX_q;
    logic [WIDTH-1:0] preY_q;
    logic [WIDTH-1:0] dispX_q;
    logic [WIDTH-1:0] dispY_q;

    // Write-back beat registers, held between beats.
    logic [WIDTH-1:0] newX_q;
    logic [WIDTH-1:0] newY_q;
    logic [WIDTH-1:0] newPreX_q;
    logic [WIDTH-1:0] newPreY_q;
    logic [WIDTH-1:0] wrIndex_q;
    logic             overflow_q;

    logic signed [WIDTH+1:0] sumX;
    logic signed [WIDTH+1:0] sumY;
    logic [WIDTH-1:0]        satX;
    logic [WIDTH-1:0]        satY;
    logic                    clipX;
    logic                    clipY;

    // Two guard bits are enough: |2*cur - prev + disp| stays below 2^(WIDTH+1).
    function automatic logic signed [WIDTH+1:0] widen(input logic [WIDTH-1:0] v);
        return {{2{v[WIDTH-1]}}, v};
    endfunction

    // Verlet arithmetic on the captured operands, then clamp each axis back
    // into the signed WIDTH-bit range and flag whether it had to clamp.
    always_comb begin
        sumX  = (widen(curX_q) <<< 1) - widen(preX_q) + widen(dispX_q);
        sumY  = (widen(curY_q) <<< 1) - widen(preY_q) + widen(dispY_q);
        clipX = 1'b0;
        clipY = 1'b0;
        satX  = sumX[WIDTH-1:0];
        satY  = sumY[WIDTH-1:0];
        if (sumX > SAT_MAX) begin
            satX  = SAT_MAX[WIDTH-1:0];
            clipX = 1'b1;
        end else if (sumX < SAT_MIN) begin
            satX  = SAT_MIN[WIDTH-1:0];
            clipX = 1'b1;
        end
        if (sumY > SAT_MAX) begin
            satY  = SAT_MAX[WIDTH-1:0];
            clipY = 1'b1;
        end else if (sumY < SAT_MIN) begin
            satY  = SAT_MIN[WIDTH-1:0];
            clipY = 1'b1;
        end
    end

    // Next-state logic for the node walk. The index only advances out of
    // WRITE and stops at the last node, so it never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SELECT;
                    idx_d   = '0;
                end
            end
            SELECT: begin
                state_d = CALC;
            end
            CALC: begin
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + WIDTH'(1);
                    state_d = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The selector is registered, so it is computed from the state and
    // index we are about to enter; that way it is valid for the whole
    // SELECT cycle.
    always_comb begin
        selector_d = '0;
        if (state_d == SELECT) begin
            selector_d = WIDTH'(1) << idx_d;
        end
    end

    // All sequential state. Operand capture happens on the SELECT exit edge,
    // the saturated results and the write index are loaded on the CALC exit
    // edge so they are stable throughout WRITE and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            selector_q <= '0;
            curX_q     <= '0;
            curY_q     <= '0;
            preX_q     <= '0;
            preY_q     <= '0;
            dispX_q    <= '0;
            dispY_q    <= '0;
            newX_q     <= '0;
            newY_q     <= '0;
            newPreX_q  <= '0;
            newPreY_q  <= '0;
            wrIndex_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            selector_q <= selector_d;

            if (state_q == IDLE && bus.start) begin
                overflow_q <= 1'b0;
            end

            if (state_q == SELECT) begin
                curX_q  <= bus.x_position;
                curY_q  <= bus.y_position;
                preX_q  <= bus.pre_x_position;
                preY_q  <= bus.pre_y_position;
                dispX_q <= bus.disp_x;
                dispY_q <= bus.disp_y;
            end

            if (state_q == CALC) begin
                newX_q     <= satX;
                newY_q     <= satY;
                newPreX_q  <= curX_q;
                newPreY_q  <= curY_q;
                wrIndex_q  <= idx_q;
                overflow_q <= overflow_q | clipX | clipY;
            end
        end
    end

    // Strobes decode straight from the registered state.
    always_comb begin
        bus.selector  = selector_q;
        bus.wr_en     = (state_q == WRITE);
        bus.wr_index  = wrIndex_q;
        bus.new_x     = newX_q;
        bus.new_y     = newY_q;
        bus.new_pre_x = newPreX_q;
        bus.new_pre_y = newPreY_q;
        bus.busy      = (state_q == SELECT) || (state_q == CALC) || (state_q == WRITE);
        bus.done      = (state_q == DONE);
        bus.overflow  = overflow_q;
    end

endmodule

// File: tb/tb_verlet_position_updater.sv
// ---------------------------------------------------------------------------
// tb_verlet_position_updater
//
// Directed bench for verlet_position_updater with a scoreboard: each pass
// pushes its hand-computed write-back beats into a queue, and a monitor
// pops and compares whenever the DUT raises wr_en.
// ---------------------------------------------------------------------------
module tb_verlet_position_updater;

    localparam int WIDTH      = 32;
    localparam int NODE_COUNT = 5;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] nx;
        logic [31:0] ny;
        logic [31:0] npx;
        logic [31:0] npy;
        logic        ovf;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    beat_t sbq[$];

    // Node RAM contents and the hand-computed results for each node.
    logic [31:0] memX  [NODE_COUNT];
    logic [31:0] memPX [NODE_COUNT];
    logic [31:0] memDX [NODE_COUNT];
    logic [31:0] memY  [NODE_COUNT];
    logic [31:0] memPY [NODE_COUNT];
    logic [31:0] memDY [NODE_COUNT];
    logic [31:0] expX  [NODE_COUNT];
    logic [31:0] expY  [NODE_COUNT];
    logic        expClip [NODE_COUNT];

    int selIdx;

    always #5 clk = ~clk;

    verlet_position_updater_if #(.WIDTH(WIDTH)) bus ();

    verlet_position_updater #(
        .WIDTH      (WIDTH),
        .NODE_COUNT (NODE_COUNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The selector mux in front of the updater: decode the one-hot select
    // and present that node's data.
    always_comb begin
        selIdx = 0;
        for (int i = 0; i < NODE_COUNT; i++) begin
            if (bus.selector[i]) selIdx = i;
        end
        bus.x_position     = memX[selIdx];
        bus.y_position     = memY[selIdx];
        bus.pre_x_position = memPX[selIdx];
        bus.pre_y_position = memPY[selIdx];
        bus.disp_x         = memDX[selIdx];
        bus.disp_y         = memDY[selIdx];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loadNode(input int i,
                            input logic [31:0] x, input logic [31:0] px, input logic [31:0] dx,
                            input logic [31:0] y, input logic [31:0] py, input logic [31:0] dy,
                            input logic [31:0] ex, input logic [31:0] ey, input logic clip);
        memX[i] = x;  memPX[i] = px; memDX[i] = dx;
        memY[i] = y;  memPY[i] = py; memDY[i] = dy;
        expX[i] = ex; expY[i] = ey;  expClip[i] = clip;
    endtask

    task automatic loadBasic();
        for (int i = 0; i < NODE_COUNT; i++)
            loadNode(i, 100, 90, 5, -20, -10, 0, 115, -30, 1'b0);
    endtask

    // Push the expected beats for the first 'beats' nodes, then pulse start
    // so that it is sampled on the next edge (edge 0). Returns in cycle 1.
    task automatic applyStimulus(input int beats);
        logic ovf;
        beat_t b;
        ovf = 1'b0;
        for (int i = 0; i < beats; i++) begin
            ovf   = ovf | expClip[i];
            b.idx = 32'(i);
            b.nx  = expX[i];
            b.ny  = expY[i];
            b.npx = memX[i];
            b.npy = memY[i];
            b.ovf = ovf;
            sbq.push_back(b);
        end
        bus.start = 1'b1;
        nextCycle();
        bus.start = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " selector"},  bus.selector, 32'd0);
        checkOutput({name, " wr_en"},     32'(bus.wr_en), 32'd0);
        checkOutput({name, " wr_index"},  bus.wr_index, 32'd0);
        checkOutput({name, " new_x"},     bus.new_x, 32'd0);
        checkOutput({name, " new_y"},     bus.new_y, 32'd0);
        checkOutput({name, " new_pre_x"}, bus.new_pre_x, 32'd0);
        checkOutput({name, " new_pre_y"}, bus.new_pre_y, 32'd0);
        checkOutput({name, " busy"},      32'(bus.busy), 32'd0);
        checkOutput({name, " done"},      32'(bus.done), 32'd0);
        checkOutput({name, " overflow"},  32'(bus.overflow), 32'd0);
    endtask

    // Full pass: start, overflow cleared in cycle 1, done in cycle 16,
    // idle with sticky overflow in cycle 17.
    task automatic runPass(input string name, input logic expOvf);
        int cyc;
        applyStimulus(NODE_COUNT);
        checkOutput({name, " overflow cleared"}, 32'(bus.overflow), 32'd0);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            nextCycle();
            cyc++;
        end
        checkOutput({name, " done cycle"}, 32'(cyc), 32'd16);
        checkOutput({name, " busy at done"}, 32'(bus.busy), 32'd0);
        nextCycle();
        checkOutput({name, " done after"}, 32'(bus.done), 32'd0);
        checkOutput({name, " busy after"}, 32'(bus.busy), 32'd0);
        checkOutput({name, " overflow sticky"}, 32'(bus.overflow), 32'(expOvf));
    endtask

    // Monitor: every write-back beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected beat: got wr_index=%0d with empty scoreboard", bus.wr_index);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                if (bus.wr_index !== e.idx || bus.new_x !== e.nx || bus.new_y !== e.ny ||
                    bus.new_pre_x !== e.npx || bus.new_pre_y !== e.npy || bus.overflow !== e.ovf) begin
                    bad++;
                    $display("[TB] FAIL beat: got idx=%0d x=%h y=%h px=%h py=%h ovf=%b expected idx=%0d x=%h y=%h px=%h py=%h ovf=%b",
                             bus.wr_index, bus.new_x, bus.new_y, bus.new_pre_x, bus.new_pre_y, bus.overflow,
                             e.idx, e.nx, e.ny, e.npx, e.npy, e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        rst       = 1'b1;
        loadBasic();
        nextCycle();
        nextCycle();
        rst = 1'b0;
        checkAllZero("reset");

        // Uniform update on every node.
        $display("[TB] basic pass");
        runPass("basic", 1'b0);

        // Per-node vectors, including a zero-displacement node and a
        // positive clip on the last node.
        $display("[TB] varied pass with positive saturation");
        loadNode(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        loadNode(1, 7, 10, -3, -5, -8, 2, 1, 0, 1'b0);
        loadNode(2, 1000, 1000, 1, 50, 60, -7, 1001, 33, 1'b0);
        loadNode(3, -300, -250, 20, 12, 0, 0, -330, 24, 1'b0);
        loadNode(4, 32'h7FFF_FFF0, 0, 0, 1, 1, 1, 32'h7FFF_FFFF, 2, 1'b1);
        runPass("varied", 1'b1);

        // Negative clip in the middle of the pass; overflow must stay set
        // for the remaining beats.
        $display("[TB] negative saturation pass");
        loadBasic();
        loadNode(2, 32'h8000_0000, 1, -1, -20, -10, 0, 32'h8000_0000, -30, 1'b1);
        runPass("negsat", 1'b1);

        // Cycle-accurate timing with start pulses while busy and in DONE.
        $display("[TB] timing pass with ignored starts");
        loadBasic();
        applyStimulus(NODE_COUNT);
        for (int c = 1; c <= 20; c++) begin
            logic        expWr;
            logic [31:0] expSel;
            expWr  = (c % 3 == 0) && (c >= 3) && (c <= 15);
            expSel = ((c % 3 == 1) && (c <= 13)) ? (32'd1 << ((c - 1) / 3)) : 32'd0;
            checkOutput($sformatf("timing c%0d wr_en", c), 32'(bus.wr_en), 32'(expWr));
            checkOutput($sformatf("timing c%0d selector", c), bus.selector, expSel);
            checkOutput($sformatf("timing c%0d busy", c), 32'(bus.busy), 32'((c >= 1) && (c <= 15)));
            checkOutput($sformatf("timing c%0d done", c), 32'(bus.done), 32'(c == 16));
            if (expWr) checkOutput($sformatf("timing c%0d wr_index", c), bus.wr_index, 32'((c / 3) - 1));
            bus.start = (c == 4 || c == 16);
            nextCycle();
        end
        bus.start = 1'b0;

        // Reset asserted in cycle 8: two beats land, then everything clears.
        $display("[TB] reset mid-pass");
        loadBasic();
        applyStimulus(2);
        for (int c = 1; c < 8; c++) nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkAllZero("mid-pass reset");
        checkOutput("beats before reset", 32'(sbq.size()), 32'd0);
        for (int c = 0; c < 6; c++) nextCycle();
        runPass("restart", 1'b0);

        nextCycle();
        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/verlet_position_updater.md
Name: verlet_position_updater

Overview:
- Sequential stage that sits directly downstream of the node input selector in the graph-layout datapath.
- Walks every node in order. For each one it drives a one-hot selector, captures the current and previous positions plus the per-node displacement from the force stage, and computes the Verlet update.
- Emits one write-back beat per node to the node position RAM. One full pass over all nodes is one simulation step.

Parameters:
- WIDTH, 32, bit width of every position, displacement and selector word (signed two's complement values).
- NODE_COUNT, 5, number of nodes per pass; must satisfy 1 <= NODE_COUNT <= WIDTH.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins one pass; sampled only in IDLE.
- x_position  input  WIDTH  current x of the selected node.
- y_position  input  WIDTH  current y of the selected node.
- pre_x_position  input  WIDTH  previous x of the selected node.
- pre_y_position  input  WIDTH  previous y of the selected node.
- disp_x  input  WIDTH  signed accel*dt^2 in x for the selected node, from the force stage.
- disp_y  input  WIDTH  signed accel*dt^2 in y for the selected node, from the force stage.
- selector  output  WIDTH  one-hot node select, registered.
- wr_en  output  1  write-back strobe, one cycle per node.
- wr_index  output  WIDTH  index of the node being written.
- new_x  output  WIDTH  updated x.
- new_y  output  WIDTH  updated y.
- new_pre_x  output  WIDTH  new previous x (old x).
- new_pre_y  output  WIDTH  new previous y (old y).
- busy  output  1  high from SELECT through WRITE.
- done  output  1  one-cycle pulse at end of pass.
- overflow  output  1  sticky; set if any result saturated during the pass.

Behaviour:
- Reset: every output is 0 and the internal index is 0. The FSM goes to IDLE on the same edge. Reset mid-pass aborts it with no further wr_en, and the RAM keeps whatever was already written.
- States: IDLE, SELECT, CALC, WRITE, DONE.
- IDLE -> SELECT when start=1.
  - On that edge: idx<=0, overflow<=0.
  - start in any other state is ignored; it is not queued.
- SELECT
  - selector = 1<<idx; it is 0 in every other state.
  - On exit edge: register x, y, pre_x, pre_y, disp_x, disp_y.
  - Next state is CALC.
- CALC
  - Compute in WIDTH+2 signed bits: nx = 2*x - pre_x + disp_x; ny likewise.
  - Saturate each result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register new_x/new_y. Set new_pre_x=x and new_pre_y=y (never saturated).
  - Set overflow if either axis clipped.
  - Next state is WRITE.
- WRITE
  - wr_en=1 for exactly this cycle; wr_index=idx; new_* stable.
  - If idx==NODE_COUNT-1, go to DONE. Otherwise idx<=idx+1 and go to SELECT.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Outputs between beats:
  - new_* and wr_index hold their last values outside WRITE.
  - wr_en is 0 outside WRITE.
  - overflow holds until the next accepted start or rst.
- Latency:
  - start sampled at edge 0 gives node k its WRITE in cycle 3k+3.
  - done is high in cycle 3*NODE_COUNT+1.
  - A new start is accepted no earlier than the edge ending the cycle after DONE.
- Boundaries:
  - NODE_COUNT=1 gives a single SELECT/CALC/WRITE followed by DONE.
  - The index never wraps past NODE_COUNT-1.
  - Zero-displacement nodes still get a write beat.

Test Plan:
- Basic update, all nodes: x=100, pre_x=90, disp_x=5, y=-20, pre_y=-10, disp_y=0 → every beat has new_x=115, new_pre_x=100, new_y=-30, new_pre_y=-20, and overflow=0.
- Timing, N=5: start pulse at cycle 0 →
  - wr_en high only in cycles 3, 6, 9, 12, 15 with wr_index 0..4.
  - selector =1, 2, 4, 8, 16 in cycles 1, 4, 7, 10, 13, and 0 elsewhere.
  - busy high in cycles 1–15; done high only in cycle 16.
- Positive saturation: x=0x7FFFFFF0, pre_x=0, disp_x=0 → new_x=0x7FFFFFFF, new_pre_x=0x7FFFFFF0, and overflow stays 1 after done. Next start clears overflow to 0.
- Negative saturation: x=0x80000000, pre_x=1, disp_x=-1 → new_x=0x80000000, overflow=1.
- Start while busy: assert start in cycles 4 and 16 → still exactly 5 wr_en beats, done only at 16, FSM back in IDLE at 17.
- Reset mid-pass: rst high in cycle 8 → in cycle 9 all outputs are 0 and the state is IDLE. No wr_en until a new start, which then restarts at wr_index 0.
